// File: rtl/experiment_ctrl_pkg.sv
// Shared types for the experiment controller: command codes, FSM states and
// aging sensor modes.
// Latency: n/a (declarations only). Backpressure: n/a.
package experiment_ctrl_pkg;

  localparam int CMD_W        = 3;
  localparam int MEAS_COUNT_W = 16;

  typedef enum logic [CMD_W-1:0] {
    WRITE_OP            = 3'd0,
    READ_MEAS_COUNT     = 3'd1,
    READ_RESULT         = 3'd2,
    TRIGGER_MEASUREMENT = 3'd3,
    READ_READY          = 3'd4,
    READ_AGING_SENSOR   = 3'd5,
    MODULE_SELECT       = 3'd6,
    CMD_RESERVED_7      = 3'd7
  } EXPERIMENT_CMDS;

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_RESP = 1'b1
  } CMD_FSM_STATE;

  typedef enum logic [1:0] {
    AGING_IDLE        = 2'd0,
    AGING_STRESS      = 2'd1,
    AGING_MEASUREMENT = 2'd2
  } AGING_SENSOR_MODE;

endpackage

// File: rtl/experiment_ctrl_if.sv
// Host command/response channel of the experiment controller.
// Latency: n/a (wires only). Backpressure: valid/ready on both directions.
// Ports: master = host side (drives cmd_*, rsp_ready); slave = controller side.
interface experiment_ctrl_if #(
  parameter int OP_WIDTH     = 16,
  parameter int SENSOR_WIDTH = 32
);
  logic                                 cmd_valid;
  logic                                 cmd_ready;
  logic [experiment_ctrl_pkg::CMD_W-1:0] cmd_code;
  logic [2*OP_WIDTH-1:0]                cmd_data;
  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [SENSOR_WIDTH-1:0]              rsp_data;
  logic                                 rsp_err;

  modport master (
    output cmd_valid, cmd_code, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/experiment_ctrl_aging_meas_timer.sv
// Aging measurement window timer: runs MEAS_CYCLES cycles, then samples the
// selected sensor and raises ready. Latency: MEAS_CYCLES cycles start->ready.
// Backpressure: none; start is only issued by the controller when not busy.
// Ports: start_i (one-cycle pulse), sel_i, sens_value_i in; busy_o, ready_o,
// sample_o out; meas_count_o only when EXPCTRL_MEAS_COUNT_EN is defined.
module aging_meas_timer
  import experiment_ctrl_pkg::*;
#(
  parameter int N_MODULES    = 4,
  parameter int SENSOR_WIDTH = 32,
  parameter int MEAS_CYCLES  = 1024,
  parameter int SEL_W        = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [SEL_W-1:0]                  sel_i,
  input  logic [N_MODULES*SENSOR_WIDTH-1:0] sens_value_i,
  output logic                              busy_o,
  output logic                              ready_o,
  output logic [SENSOR_WIDTH-1:0]           sample_o
`ifdef EXPCTRL_MEAS_COUNT_EN
  ,output logic [MEAS_COUNT_W-1:0]          meas_count_o
`endif
);

  localparam int CNT_W = $clog2(MEAS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEAS_CYCLES - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    ready_q, ready_d;
  logic [SENSOR_WIDTH-1:0] sample_q, sample_d;
  logic                    done;

  // The window closes on the edge that ends its last cycle.
  assign done = busy_q && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    sample_d = sample_q;
    if (start_i) begin
      busy_d  = 1'b1;
      ready_d = 1'b0;
      cnt_d   = '0;
    end else if (done) begin
      busy_d   = 1'b0;
      ready_d  = 1'b1;
      cnt_d    = '0;
      sample_d = sens_value_i[sel_i*SENSOR_WIDTH +: SENSOR_WIDTH];
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      sample_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      sample_q <= sample_d;
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign sample_o = sample_q;

`ifdef EXPCTRL_MEAS_COUNT_EN
  logic [MEAS_COUNT_W-1:0] mcnt_q, mcnt_d;

  always_comb begin
    mcnt_d = mcnt_q;
    if (done && (mcnt_q != {MEAS_COUNT_W{1'b1}})) mcnt_d = mcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt_q <= '0;
    else        mcnt_q <= mcnt_d;
  end

  assign meas_count_o = mcnt_q;
`endif

endmodule

// File: rtl/experiment_ctrl.sv
// Experiment controller: decodes host commands for an array of DUTs and aging
// sensors, keeps unmeasured modules stressed. Latency: response 1 cycle after
// accept. Backpressure: one outstanding response; cmd_ready low until rsp taken.
// Ports: clk, rst_n; host (experiment_ctrl_if.slave); mod_ena/mod_xin/mod_yin
// out, mod_rout in; sens_mode out, sens_value in.
// Optional feature: EXPCTRL_MEAS_COUNT_EN adds READ_MEAS_COUNT (code 1).
module experiment_ctrl
  import experiment_ctrl_pkg::*;
#(
  parameter int N_MODULES    = 4,
  parameter int OP_WIDTH     = 16,
  parameter int RES_WIDTH    = 20,
  parameter int SENSOR_WIDTH = 32,
  parameter int MEAS_CYCLES  = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  experiment_ctrl_if.slave                  host,
  output logic [N_MODULES-1:0]              mod_ena,
  output logic [OP_WIDTH-1:0]               mod_xin,
  output logic [OP_WIDTH-1:0]               mod_yin,
  input  logic [N_MODULES*RES_WIDTH-1:0]    mod_rout,
  output logic [2*N_MODULES-1:0]            sens_mode,
  input  logic [N_MODULES*SENSOR_WIDTH-1:0] sens_value
);

  localparam int SEL_W = (N_MODULES > 1) ? $clog2(N_MODULES) : 1;

  if (SENSOR_WIDTH < RES_WIDTH) begin : g_bad_sensor_width
    $error("experiment_ctrl: SENSOR_WIDTH must be >= RES_WIDTH");
  end
  if (N_MODULES < 1 || N_MODULES > 16) begin : g_bad_n_modules
    $error("experiment_ctrl: N_MODULES must be 1..16");
  end
  if (MEAS_CYCLES < 2) begin : g_bad_meas_cycles
    $error("experiment_ctrl: MEAS_CYCLES must be >= 2");
  end

  CMD_FSM_STATE            state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [OP_WIDTH-1:0]     xin_q, xin_d, yin_q, yin_d;
  logic [N_MODULES-1:0]    ena_q, ena_d;
  logic [SENSOR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    stress_q;
  logic                    cmd_accept;
  logic                    meas_start, meas_busy, meas_ready;
  logic [SENSOR_WIDTH-1:0] meas_sample;
`ifdef EXPCTRL_MEAS_COUNT_EN
  logic [MEAS_COUNT_W-1:0] meas_count;
`endif

  assign cmd_accept = host.cmd_valid && (state_q == CMD_IDLE);

  aging_meas_timer #(
    .N_MODULES    (N_MODULES),
    .SENSOR_WIDTH (SENSOR_WIDTH),
    .MEAS_CYCLES  (MEAS_CYCLES),
    .SEL_W        (SEL_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (meas_start),
    .sel_i        (sel_q),
    .sens_value_i (sens_value),
    .busy_o       (meas_busy),
    .ready_o      (meas_ready),
    .sample_o     (meas_sample)
`ifdef EXPCTRL_MEAS_COUNT_EN
    ,.meas_count_o (meas_count)
`endif
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CMD_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      CMD_IDLE: if (host.cmd_valid)  state_d = CMD_RESP;
      CMD_RESP: if (host.rsp_ready)  state_d = CMD_IDLE;
      default:                       state_d = CMD_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    host.cmd_ready = (state_q == CMD_IDLE);
    host.rsp_valid = (state_q == CMD_RESP);
    host.rsp_data  = rsp_data_q;
    host.rsp_err   = rsp_err_q;
  end

  // Command execution; response registers only change on an accept so they
  // hold steady while the host stalls.
  always_comb begin
    sel_d      = sel_q;
    xin_d      = xin_q;
    yin_d      = yin_q;
    ena_d      = '0;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    meas_start = 1'b0;
    if (cmd_accept) begin
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      case (host.cmd_code)
        WRITE_OP: begin
          xin_d = host.cmd_data[2*OP_WIDTH-1:OP_WIDTH];
          yin_d = host.cmd_data[OP_WIDTH-1:0];
          ena_d = N_MODULES'(1) << sel_q;
        end
        READ_RESULT:
          rsp_data_d = SENSOR_WIDTH'(mod_rout[sel_q*RES_WIDTH +: RES_WIDTH]);
        TRIGGER_MEASUREMENT: begin
          if (meas_busy) rsp_err_d  = 1'b1;
          else           meas_start = 1'b1;
        end
        READ_READY:
          rsp_data_d = SENSOR_WIDTH'(meas_ready);
        READ_AGING_SENSOR: begin
          rsp_data_d = meas_sample;
          rsp_err_d  = !meas_ready;
        end
        MODULE_SELECT: begin
          // The whole operand is the index, so out-of-range values whose low
          // bits happen to alias a valid module are still rejected.
          if ((host.cmd_data >= (2*OP_WIDTH)'(N_MODULES)) || meas_busy)
            rsp_err_d = 1'b1;
          else
            sel_d = host.cmd_data[SEL_W-1:0];
        end
`ifdef EXPCTRL_MEAS_COUNT_EN
        READ_MEAS_COUNT:
          rsp_data_d = SENSOR_WIDTH'(meas_count);
`endif
        default: rsp_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      xin_q      <= '0;
      yin_q      <= '0;
      ena_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      stress_q   <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      xin_q      <= xin_d;
      yin_q      <= yin_d;
      ena_q      <= ena_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      stress_q   <= 1'b1;   // modules go to stress one edge after reset release
    end
  end

  assign mod_ena = ena_q;
  assign mod_xin = xin_q;
  assign mod_yin = yin_q;

  always_comb begin
    sens_mode = '0;
    for (int i = 0; i < N_MODULES; i++) begin
      if (stress_q)
        sens_mode[2*i +: 2] = (meas_busy && (sel_q == SEL_W'(i))) ?
                              AGING_MEASUREMENT : AGING_STRESS;
    end
  end

endmodule
